// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data SRAM port arbiter.
package mem_arb_pkg;

  // Which requester owns the SRAM response arriving next cycle.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_owner_e;

  // Default number of back-to-back data grants tolerated while fetch waits.
  localparam int STARVE_LIMIT_DEF = 4;

  // SRAM word width.
  localparam int DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between the fetch stage
// (read-only) and the memory stage (read/write). Data has fixed priority;
// fetch is forced through after STARVE_LIMIT consecutive data grants.
// Responses come back one cycle after the grant and are steered using the
// registered owner of that grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int AW           = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // fetch port
  input  logic              inst_req,
  input  logic [AW-1:0]     inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data port
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [AW-1:0]     data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // SRAM port
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  resp_owner_e r_resp_owner;
  resp_owner_e w_resp_owner_nxt;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_cnt_nxt;

  logic w_force_inst;
  logic w_grant_data;
  logic w_grant_inst;

  // Grant decision: data first unless fetch has waited long enough.
  // Everything is gated by resetn so nothing is granted while in reset.
  assign w_force_inst = inst_req && (r_starve_cnt == LP_LIMIT);
  assign w_grant_data = resetn && data_req && !w_force_inst;
  assign w_grant_inst = resetn && inst_req && !w_grant_data;

  // Request mux: put the granted requester onto the SRAM port.
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 4'b0000;
    mem_addr     = inst_addr;
    mem_wdata    = data_wdata;
    if (w_grant_data) begin
      data_addr_ok = 1'b1;
      mem_en       = 1'b1;
      mem_addr     = data_addr;
      mem_we       = data_wr ? data_wstrb : 4'b0000;
    end else if (w_grant_inst) begin
      inst_addr_ok = 1'b1;
      mem_en       = 1'b1;
      mem_addr     = inst_addr;
    end
  end

  // Next-state for the response owner and the fetch starvation counter.
  always_comb begin
    w_resp_owner_nxt = RESP_NONE;
    w_starve_cnt_nxt = r_starve_cnt;
    if (w_grant_data) begin
      w_resp_owner_nxt = RESP_DATA;
    end else if (w_grant_inst) begin
      w_resp_owner_nxt = RESP_INST;
    end
    if (w_grant_inst || !inst_req) begin
      w_starve_cnt_nxt = 4'd0;
    end else if (w_grant_data && (r_starve_cnt != LP_LIMIT)) begin
      w_starve_cnt_nxt = r_starve_cnt + 4'd1;
    end
  end

  // State registers; reset drops any response owed to a pre-reset grant.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_resp_owner <= RESP_NONE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_resp_owner <= w_resp_owner_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  // Response steering from the registered owner only.
  assign inst_data_ok = resetn && (r_resp_owner == RESP_INST);
  assign data_data_ok = resetn && (r_resp_owner == RESP_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of per-cycle requests and
// expected grants, a small SRAM model, and a response scoreboard.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT_DEF), .AW(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Initial SRAM contents as a function of word index.
  function automatic logic [31:0] dflt(input logic [11:0] idx);
    return {idx ^ 12'h5A3, 4'h7, ~idx, 4'h1};
  endfunction

  // SRAM model driven by the DUT's memory port (read-first, 1-cycle latency).
  logic [31:0] sram [4096];
  logic [31:0] sram_q;
  assign mem_rdata = sram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      sram_q <= sram[mem_addr[13:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference memory updated only from the bench's own intended writes.
  logic [31:0] ref_mem [4096];

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [3:0]  strb;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [1:0]  g;      // 0 none, 1 inst, 2 data
  } vec_t;

  typedef struct {
    logic [1:0]  owner;
    logic        wr;
    logic [31:0] rdata;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [1:0] GN = 2'd0, GI = 2'd1, GD = 2'd2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic ireq, input logic [31:0] iaddr,
                     input logic dreq, input logic dwr, input logic [3:0] strb,
                     input logic [31:0] daddr, input logic [31:0] wdata,
                     input logic [1:0] g);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwr = dwr;
    v.strb = strb; v.daddr = daddr; v.wdata = wdata; v.g = g;
    vecs.push_back(v);
  endtask

  task automatic both(input logic [1:0] g);
    add(0, 1, 32'h1C00_0040, 1, 0, 4'h0, 32'h1C00_2000, 32'h0, g);
  endtask

  task automatic idle();
    add(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, GN);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    sb_t e;
    logic [31:0] w;
    @(posedge clk);
    #1;
    resetn = !v.rst; inst_req = v.ireq; inst_addr = v.iaddr;
    data_req = v.dreq; data_wr = v.dwr; data_wstrb = v.strb;
    data_addr = v.daddr; data_wdata = v.wdata;
    @(negedge clk);
    // response owed from the previous cycle's grant
    e.owner = GN; e.wr = 1'b0; e.rdata = '0;
    if (sb.size() > 0) e = sb.pop_front();
    if (v.rst) begin
      e.owner = GN;
      sb.delete();
    end
    chk($sformatf("v%0d inst_data_ok", idx), 32'(inst_data_ok), 32'(e.owner == GI));
    chk($sformatf("v%0d data_data_ok", idx), 32'(data_data_ok), 32'(e.owner == GD));
    if (e.owner == GI) chk($sformatf("v%0d inst_rdata", idx), inst_rdata, e.rdata);
    if (e.owner == GD && !e.wr) chk($sformatf("v%0d data_rdata", idx), data_rdata, e.rdata);
    // grant of this cycle
    chk($sformatf("v%0d inst_addr_ok", idx), 32'(inst_addr_ok), 32'(v.g == GI));
    chk($sformatf("v%0d data_addr_ok", idx), 32'(data_addr_ok), 32'(v.g == GD));
    chk($sformatf("v%0d mem_en", idx), 32'(mem_en), 32'(v.g != GN));
    chk($sformatf("v%0d mem_we", idx), 32'(mem_we),
        32'((v.g == GD && v.dwr) ? v.strb : 4'h0));
    if (v.g == GI) begin
      chk($sformatf("v%0d mem_addr", idx), mem_addr, v.iaddr);
      e.owner = GI; e.wr = 1'b0; e.rdata = ref_mem[v.iaddr[13:2]];
      sb.push_back(e);
    end else if (v.g == GD) begin
      chk($sformatf("v%0d mem_addr", idx), mem_addr, v.daddr);
      e.owner = GD; e.wr = v.dwr; e.rdata = ref_mem[v.daddr[13:2]];
      if (v.dwr) begin
        chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
        w = ref_mem[v.daddr[13:2]];
        for (int b = 0; b < 4; b++)
          if (v.strb[b]) w[8*b +: 8] = v.wdata[8*b +: 8];
        ref_mem[v.daddr[13:2]] = w;
      end
      sb.push_back(e);
    end
  endtask

  initial begin
    int waited;
    for (int i = 0; i < 4096; i++) begin
      sram[i] = dflt(12'(i));
      ref_mem[i] = dflt(12'(i));
    end
    sram_q = '0;

    // reset with both requests high: nothing may be granted
    add(1, 1, 32'h1C00_0000, 1, 1, 4'hF, 32'h1C00_1000, 32'h1234_5678, GN);
    add(1, 1, 32'h1C00_0000, 1, 1, 4'hF, 32'h1C00_1000, 32'h1234_5678, GN);
    // fetch only
    add(0, 1, 32'h1C00_0000, 0, 0, 4'h0, 32'h0, 32'h0, GI);
    idle();
    // data write of the low half, then read back
    add(0, 0, 32'h0, 1, 1, 4'b0011, 32'h1C00_1000, 32'hDEAD_BEEF, GD);
    add(0, 0, 32'h0, 1, 0, 4'h0, 32'h1C00_1000, 32'h0, GD);
    idle();
    // contention for 12 cycles
    for (int i = 0; i < 12; i++) both(((i % 5) == 4) ? GI : GD);
    idle();
    // counter clears when inst_req drops
    both(GD); both(GD);
    add(0, 0, 32'h0, 1, 0, 4'h0, 32'h1C00_2004, 32'h0, GD);
    both(GD); both(GD); both(GD); both(GD); both(GI);
    idle();
    // back-to-back alternation
    add(0, 1, 32'h1C00_0080, 0, 0, 4'h0, 32'h0, 32'h0, GI);
    add(0, 0, 32'h0, 1, 0, 4'h0, 32'h1C00_1000, 32'h0, GD);
    add(0, 1, 32'h1C00_0084, 0, 0, 4'h0, 32'h0, 32'h0, GI);
    idle(); idle(); idle();
    // reset mid-flight: third data read's response must be dropped
    both(GD); both(GD); both(GD);
    add(1, 1, 32'h1C00_0040, 1, 0, 4'h0, 32'h1C00_2000, 32'h0, GN);
    idle();
    both(GD); both(GD); both(GD); both(GD); both(GI);
    idle();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // fetch wait under continuous data requests, bounded
    waited = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      inst_req = 1'b1; inst_addr = 32'h1C00_0100;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1C00_2008;
      @(negedge clk);
      waited++;
      if (inst_addr_ok) break;
      chk($sformatf("wait%0d data_addr_ok", c), 32'(data_addr_ok), 32'd1);
    end
    chk("starve_wait", 32'(waited), 32'(STARVE_LIMIT_DEF + 1));
    @(posedge clk);
    #1;
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    chk("final idle mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("final inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("final data_data_ok", 32'(data_data_ok), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous instruction/data SRAM between the fetch stage (read-only requester) and the memory stage (read/write requester) using a req/addr_ok/data_ok handshake. It sits between the pipeline stages and the SRAM. Each cycle it grants at most one request, with fixed data-side priority and a starvation guard for fetch. It routes the next-cycle SRAM response back to the requester that issued it.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants made while inst_req is pending; after that many, the next grant is forced to inst. Range 1..15.
- AW, 32: address width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- inst_req  in  1  fetch request; held with inst_addr stable until inst_addr_ok
- inst_addr  in  AW  fetch address (word aligned)
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch read data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request; held with its attributes stable until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte enables for writes
- data_addr  in  AW  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data read data valid, or write acknowledged, this cycle
- data_rdata  out  32  data read data
- mem_en  out  1  SRAM enable
- mem_we  out  4  SRAM byte write enables
- mem_addr  out  AW  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid one cycle after mem_en

## Operation
- Grant logic is combinational on the current requests plus registered state.
  - Grant data if data_req and not force_inst.
  - Otherwise grant inst if inst_req.
  - Otherwise grant nothing.
- force_inst = inst_req && (starve_cnt == STARVE_LIMIT).
- On a grant, drive the granted requester's addr/wdata/strobes onto mem_*, assert mem_en, and assert that requester's addr_ok in the same cycle.
  - mem_we = data_wstrb only for a data write; otherwise 0.
- resp_owner register with states NONE, INST, DATA. It is loaded each cycle with the owner of this cycle's grant, or NONE if there is no grant.
- Response decode, driven from resp_owner only:
  - resp_owner == INST: inst_data_ok = 1, inst_rdata = mem_rdata.
  - resp_owner == DATA: data_data_ok = 1, data_rdata = mem_rdata. For writes, data_rdata is don't-care.
- starve_cnt (4-bit):
  - Clears when inst is granted or inst_req is low.
  - Increments on each data grant while inst_req is high.
  - Saturates at STARVE_LIMIT.
- Back-to-back grants are allowed. A data_ok for grant N and the addr_ok for grant N+1 may coincide, to the same or a different requester.
- No backpressure on responses: a requester must consume data_ok in the cycle it is asserted.
- An unaligned address is passed through unchanged; checking it is not this block's job.

## Timing
- Reset (resetn low at a clk edge):
  - resp_owner = NONE, starve_cnt = 0.
  - All addr_ok, data_ok, mem_en and mem_we read 0 combinationally while resetn is low.
  - rdata outputs are don't-care.
- Accept latency is 0: addr_ok is in the same cycle as req when granted.
- Response latency is exactly 1 cycle after addr_ok.
- Peak throughput: 1 transaction per cycle.
- Reset mid-operation: a response owed for a grant in the cycle before reset is dropped (no data_ok after reset). Requesters must discard their outstanding state on reset.
- Simultaneous inst_req and data_req: data wins unless force_inst, in which case inst wins and data waits at least 1 cycle.
- Fetch worst-case wait under continuous data_req is STARVE_LIMIT+1 cycles.
- When both requests drop, mem_en = 0 and resp_owner becomes NONE the next cycle.

## Structure
- Shared package mem_arb_pkg holds:
  - the resp_owner enum (NONE=2'd0, INST=2'd1, DATA=2'd2);
  - the STARVE_LIMIT default constant;
  - the 32-bit data width constant.
- Single flat module; no sub-module is warranted. Grant, mux, owner register and starvation counter all fit in one file.

## Test plan
- Fetch only: inst_req=1, inst_addr=0x1C000000 → inst_addr_ok same cycle, mem_addr=0x1C000000, mem_we=0. Next cycle inst_data_ok=1 and inst_rdata equals the SRAM word.
- Data write then read: write 0xDEADBEEF to 0x1C001000 with wstrb=4'b0011 → mem_we=0011, data_data_ok next cycle. Read the same address → data_rdata low half = 0xBEEF.
- Contention: both req held high for 12 cycles with STARVE_LIMIT=4 → grant pattern D,D,D,D,I repeating. Each inst_data_ok returns the fetched word; no response is misrouted.
- Back-to-back alternation: inst, data, inst on consecutive cycles → data_ok pulses alternate inst/data/inst, each exactly 1 cycle after its addr_ok.
- Reset mid-flight: grant a data read, assert resetn=0 the next cycle → no data_ok. After release, all outputs are 0 and starve_cnt is 0.
- Idle: both req low → mem_en=0, no data_ok the following cycle, starve_cnt held at 0.
